// File: rtl/led_pwm_fader.sv
// led_pwm_fader: two-channel LED brightness fader with PWM output.
// Each channel ramps its brightness towards the target pattern one step per
// prescaler tick and drives a registered PWM output from that brightness.
// Optional feature: define LED_GAMMA_EN to map brightness through a squared
// (perceptual) curve before PWM comparison; undefined gives a linear duty.
module led_pwm_fader #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] led_in,
  output logic [1:0] led_out,
  output logic       busy
);

  localparam int unsigned NCH  = 2;
  localparam int unsigned PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PS_W-1:0]     PS_LAST    = PS_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] B_MAX      = '1;
  localparam logic [PWM_BITS-1:0] B_ZERO     = '0;
  localparam logic [PWM_BITS-1:0] B_ONE      = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] B_NEAR_MAX = B_MAX - B_ONE;

  typedef enum logic [1:0] {
    S_OFF       = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_ON        = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  logic [1:0]          led_q;
  logic [PS_W-1:0]     ps_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;

  state_t              state      [NCH];
  state_t              state_next [NCH];
  logic [PWM_BITS-1:0] b          [NCH];
  logic [PWM_BITS-1:0] b_next     [NCH];
  logic [PWM_BITS-1:0] d          [NCH];
`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq       [NCH];
`endif
  logic [NCH-1:0]      drive_next;
  logic                busy_next;

  // Input pattern register: all decisions below use led_q only.
  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= led_in;
  end

  // Step prescaler: counts 0..STEP_DIV-1, tick on the last count.
  always_ff @(posedge clk) begin
    if (rst)       ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + 1'b1;
  end

  assign tick = (ps_cnt == PS_LAST);

  // Free-running PWM period counter shared by both channels.
  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Channel state and brightness registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state[i] <= S_OFF;
        b[i]     <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state[i] <= state_next[i];
        b[i]     <= b_next[i];
      end
    end
  end

  // Per-channel fade FSM; a reversal of the target wins over a pending step.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_next[i] = state[i];
      b_next[i]     = b[i];
      case (state[i])
        S_OFF: begin
          if (led_q[i]) state_next[i] = S_RAMP_UP;
        end
        S_RAMP_UP: begin
          if (!led_q[i]) begin
            state_next[i] = S_RAMP_DOWN;
          end else if (b[i] == B_MAX) begin
            state_next[i] = S_ON;
          end else if (tick) begin
            b_next[i] = b[i] + B_ONE;
            if (b[i] == B_NEAR_MAX) state_next[i] = S_ON;
          end
        end
        S_ON: begin
          if (!led_q[i]) state_next[i] = S_RAMP_DOWN;
        end
        S_RAMP_DOWN: begin
          if (led_q[i]) begin
            state_next[i] = S_RAMP_UP;
          end else if (b[i] == B_ZERO) begin
            state_next[i] = S_OFF;
          end else if (tick) begin
            b_next[i] = b[i] - B_ONE;
            if (b[i] == B_ONE) state_next[i] = S_OFF;
          end
        end
        default: begin
          state_next[i] = S_OFF;
          b_next[i]     = '0;
        end
      endcase
    end
  end

  // Duty value: linear brightness, or the upper half of brightness squared.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
`ifdef LED_GAMMA_EN
      sq[i] = {B_ZERO, b[i]} * {B_ZERO, b[i]};
      d[i]  = sq[i][2*PWM_BITS-1 -: PWM_BITS];
`else
      d[i]  = b[i];
`endif
    end
  end

  // PWM compare with forced endpoints so full and zero brightness are steady.
  always_comb begin
    drive_next = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (b[i] == B_MAX)       drive_next[i] = 1'b1;
      else if (b[i] == B_ZERO) drive_next[i] = 1'b0;
      else                     drive_next[i] = (pwm_cnt < d[i]);
    end
  end

  // Busy is taken from the next state so it lines up with the state register.
  always_comb begin
    busy_next = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (state_next[i] == S_RAMP_UP || state_next[i] == S_RAMP_DOWN)
        busy_next = 1'b1;
    end
  end

  // Registered LED drive and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_out <= '0;
      busy    <= 1'b0;
    end else begin
      led_out <= drive_next;
      busy    <= busy_next;
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: three instances (STEP_DIV=4, 1, 256).
// Stimulus threads push time-tagged expectations; one monitor compares them.
module tb_led_pwm_fader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst1, rst_g;
  logic [1:0] led_in, led_in1, led_in_g;
  logic [1:0] led_out, led_out1, led_out_g;
  logic       busy, busy1, busy_g;

  led_pwm_fader #(.PWM_BITS(8), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .led_out(led_out), .busy(busy));
  led_pwm_fader #(.PWM_BITS(8), .STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .led_in(led_in1), .led_out(led_out1), .busy(busy1));
  led_pwm_fader #(.PWM_BITS(8), .STEP_DIV(256)) dut_g (
    .clk(clk), .rst(rst_g), .led_in(led_in_g), .led_out(led_out_g), .busy(busy_g));

`ifdef LED_GAMMA_EN
  localparam int unsigned G1 = 0, G128 = 64, G200 = 156;
`else
  localparam int unsigned G1 = 1, G128 = 128, G200 = 200;
`endif

  typedef enum {S_LED, S_LED1, S_BUSY, S_B0, S_B1, S1_LED, S1_BUSY, S1_B0,
                S1_B1, S1_OK, SG_B0, SG_DUTY} sel_e;
  typedef struct {
    int unsigned cyc;
    sel_e        sel;
    logic [31:0] exp;
  } entry_t;

  entry_t      sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [255:0] hist = '0;
  int unsigned duty_cnt = 0;
  int unsigned r, r2, r3, r1, v, u, rg;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input sel_e s);
    logic ok;
    case (s)
      S_LED:   return {30'b0, led_out};
      S_LED1:  return {31'b0, led_out[1]};
      S_BUSY:  return {31'b0, busy};
      S_B0:    return {24'b0, dut.b[0]};
      S_B1:    return {24'b0, dut.b[1]};
      S1_LED:  return {30'b0, led_out1};
      S1_BUSY: return {31'b0, busy1};
      S1_B0:   return {24'b0, dut1.b[0]};
      S1_B1:   return {24'b0, dut1.b[1]};
      S1_OK: begin
        ok = (dut1.b[1] <= 8'd1) && !$isunknown({led_out1, busy1, dut1.b[1]});
        return {31'b0, ok};
      end
      SG_B0:   return {24'b0, dut_g.b[0]};
      SG_DUTY: return duty_cnt;
      default: return '1;
    endcase
  endfunction

  task automatic expect_at(input int unsigned rel, input sel_e s, input logic [31:0] e);
    entry_t en;
    en.cyc = cyc + rel;
    en.sel = s;
    en.exp = e;
    sb.push_back(en);
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: maintain the 256-sample duty window, then check due entries.
  always @(negedge clk) begin
    duty_cnt = duty_cnt + 32'(led_out_g[0] === 1'b1) - 32'(hist[255]);
    hist = {hist[254:0], (led_out_g[0] === 1'b1)};
    for (int k = int'(sb.size()) - 1; k >= 0; k--) begin
      if (sb[k].cyc == cyc) begin
        logic [31:0] a;
        a = actual(sb[k].sel);
        checks++;
        if (a !== sb[k].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                   sb[k].sel.name(), cyc, a, sb[k].exp);
        end
        sb.delete(k);
      end else if (sb[k].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s expired cyc=%0d actual=missed required=%0h",
                 sb[k].sel.name(), sb[k].cyc, sb[k].exp);
        sb.delete(k);
      end
    end
  end

  initial begin
    rst = 1'b1;  led_in = 2'b11;
    rst1 = 1'b1; led_in1 = 2'b00;
    rst_g = 1'b1; led_in_g = 2'b01;
    fork
      begin : main_dut
        for (int unsigned i = 1; i <= 3; i++) begin
          expect_at(i, S_LED, 0);
          expect_at(i, S_BUSY, 0);
        end
        wait_cyc(3);
        rst = 1'b0; r = cyc;
        expect_at(1, S_BUSY, 0);     expect_at(2, S_BUSY, 1);
        expect_at(3, S_B0, 0);       expect_at(4, S_B0, 1);
        expect_at(7, S_B0, 1);       expect_at(8, S_B0, 2);
        expect_at(1019, S_BUSY, 1);  expect_at(1020, S_BUSY, 0);
        expect_at(1020, S_B0, 255);  expect_at(1020, S_B1, 255);
        expect_at(1021, S_LED, 3);   expect_at(1030, S_LED, 3);
        wait_cyc(r + 1031);
        rst = 1'b1; led_in = 2'b00;
        expect_at(1, S_LED, 0); expect_at(1, S_BUSY, 0); expect_at(1, S_B1, 0);
        wait_cyc(r + 1032);
        rst = 1'b0; r2 = cyc;
        expect_at(3, S_BUSY, 0);   expect_at(4, S_BUSY, 1);
        expect_at(7, S_B0, 0);     expect_at(8, S_B0, 1);
        expect_at(12, S_B0, 2);    expect_at(300, S_LED1, 0);
        expect_at(404, S_B0, 100); expect_at(404, S_B1, 0);
        wait_cyc(r2 + 2);
        led_in = 2'b01;
        wait_cyc(r2 + 404);
        led_in = 2'b00;
        expect_at(2, S_B0, 100);    expect_at(3, S_B0, 100);
        expect_at(4, S_B0, 99);     expect_at(8, S_B0, 98);
        expect_at(399, S_BUSY, 1);  expect_at(400, S_BUSY, 0);
        expect_at(400, S_B0, 0);    expect_at(402, S_LED, 0);
        expect_at(496, S_B0, 0);
        wait_cyc(r2 + 902);
        led_in = 2'b01;
        expect_at(2, S_BUSY, 1); expect_at(513, S_B0, 127); expect_at(514, S_B0, 128);
        wait_cyc(r2 + 1416);
        rst = 1'b1;
        expect_at(1, S_B0, 0); expect_at(1, S_LED, 0); expect_at(1, S_BUSY, 0);
        wait_cyc(r2 + 1417);
        rst = 1'b0; r3 = cyc;
        expect_at(1, S_BUSY, 0); expect_at(1, S_LED, 0); expect_at(2, S_BUSY, 1);
        expect_at(3, S_B0, 0);   expect_at(4, S_B0, 1);  expect_at(8, S_B0, 2);
        wait_cyc(r3 + 10);
      end
      begin : fast_dut
        wait_cyc(3);
        rst1 = 1'b0; r1 = cyc;
        wait_cyc(r1 + 5);
        led_in1 = 2'b01; v = cyc;
        expect_at(2, S1_B0, 0);      expect_at(3, S1_B0, 1);
        expect_at(100, S1_B0, 98);   expect_at(256, S1_BUSY, 1);
        expect_at(257, S1_B0, 255);  expect_at(257, S1_BUSY, 0);
        expect_at(260, S1_LED, 1);   expect_at(300, S1_B0, 255);
        wait_cyc(v + 310);
        u = cyc;
        for (int unsigned i = 1; i <= 45; i++) expect_at(i, S1_OK, 1);
        expect_at(50, S1_B1, 0); expect_at(50, S1_LED, 1);
        for (int i = 0; i < 40; i++) begin
          led_in1 = {(i % 2 == 0), 1'b1};
          @(negedge clk);
        end
        led_in1 = 2'b01;
        wait_cyc(u + 52);
      end
      begin : gamma_dut
        wait_cyc(3);
        rst_g = 1'b0; rg = cyc;
        expect_at(256, SG_DUTY, 0);
        expect_at(512, SG_DUTY, G1);
        expect_at(128 * 256, SG_B0, 128);
        expect_at(129 * 256, SG_DUTY, G128);
        expect_at(201 * 256, SG_DUTY, G200);
        wait_cyc(rg + 201 * 256 + 2);
      end
    join
    repeat (20) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    foreach (sb[k]) begin
      checks++;
      failures++;
      $display("FAIL %s not reached cyc=%0d required=%0h", sb[k].sel.name(), sb[k].cyc, sb[k].exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
